// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx between NUM_REQ byte requesters, with per-requester lock.
// Define UART_ARB_FIXED_PRIO_EN to select the lowest requesting index instead of round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   lock,
    input  logic [8*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner,
    output logic [7:0]           uart_data,
    output logic                 uart_start,
    input  logic                 uart_done
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        ACK
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  owner_reg, owner_next;
    logic [7:0]        uart_data_reg, uart_data_next;
    logic [IDX_W-1:0]  last_reg, last_next;
    logic              lock_flag_reg, lock_flag_next;

    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic [7:0]        data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi] = data[8*gi +: 8];
            assign ack[gi]      = (state_reg == ACK) && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    // Requester selection; a live lock chain on the previous owner beats everyone else.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = owner_reg;
        cand      = '0;
        if (lock_flag_reg && lock[owner_reg] && req[owner_reg]) begin
            sel_valid = 1'b1;
        end else begin
`ifdef UART_ARB_FIXED_PRIO_EN
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = IDX_W'(k);
                if (req[cand]) begin
                    sel_valid = 1'b1;
                    sel_idx   = cand;
                end
            end
`else
            // Scan from farthest to nearest after last so the nearest requester wins.
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = IDX_W'((int'(last_reg) + k) % NUM_REQ);
                if (req[cand]) begin
                    sel_valid = 1'b1;
                    sel_idx   = cand;
                end
            end
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        uart_data_next = uart_data_reg;
        last_next      = last_reg;
        lock_flag_next = lock_flag_reg;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    owner_next     = sel_idx;
                    uart_data_next = data_arr[sel_idx];
                    state_next     = GRANT;
                end
            end
            GRANT: state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (uart_done) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                last_next      = owner_reg;
                lock_flag_next = lock[owner_reg];
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            uart_data_reg <= 8'h00;
            last_reg      <= IDX_W'(NUM_REQ - 1);
            lock_flag_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            uart_data_reg <= uart_data_next;
            last_reg      <= last_next;
            lock_flag_reg <= lock_flag_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign uart_start = (state_reg == START);
    assign owner      = owner_reg;
    assign uart_data  = uart_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays uart_tx and all requesters, with a scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   lock;
    logic [8*NUM_REQ-1:0] data;
    logic [NUM_REQ-1:0]   ack;
    logic                 busy;
    logic [IDX_W-1:0]     owner;
    logic [7:0]           uart_data;
    logic                 uart_start;
    logic                 uart_done;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .data       (data),
        .ack        (ack),
        .busy       (busy),
        .owner      (owner),
        .uart_data  (uart_data),
        .uart_start (uart_start),
        .uart_done  (uart_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] byte_val;
    } exp_t;

    exp_t             exp_q[$];
    logic [NUM_REQ-1:0] ack_q[$];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        exp_t e;
        e.idx = i;
        e.byte_val = b;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every start must match the next expected byte, every ack the matching owner.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && uart_start) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {30'd0, owner}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("start_owner", {30'd0, owner}, e.idx);
                chk("start_data", {24'd0, uart_data}, {24'd0, e.byte_val});
                ack_q.push_back(NUM_REQ'(1) << e.idx);
                $display("txn: start owner=%0d data=0x%02h", owner, uart_data);
            end
        end
        if (ack != '0) begin
            if (ack_q.size() == 0) chk("unexpected_ack", {28'd0, ack}, 32'd0);
            else chk("ack", {28'd0, ack}, {28'd0, ack_q.pop_front()});
            $display("txn: ack=%b", ack);
        end
    end

    task automatic wait_start(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (uart_start) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) chk("start_timeout", 32'd0, 32'd1);
    endtask

    // Plays the frame, pulses uart_done, and returns at the negedge inside the ACK cycle.
    task automatic finish_frame(input logic [7:0] exp_data, input int frame);
        repeat (frame) @(negedge clk);
        chk("data_hold", {24'd0, uart_data}, {24'd0, exp_data});
        uart_done = 1'b1;
        @(negedge clk);
        uart_done = 1'b0;
        chk("busy_in_ack", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b0; req = '0; lock = '0; data = '0; uart_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, uart_start}, 32'd0);
        chk("rst_data", {24'd0, uart_data}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte from requester 1
        req = 4'b0010; data[15:8] = 8'hA5; push(1, 8'hA5);
        @(negedge clk);
        chk("grant_busy", {31'd0, busy}, 32'd1);
        chk("grant_no_start", {31'd0, uart_start}, 32'd0);
        wait_start(lat);
        chk("start_latency", lat, 32'd1);
        @(negedge clk);
        chk("start_one_cycle", {31'd0, uart_start}, 32'd0);
        finish_frame(8'hA5, 3);
        req = '0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack", {28'd0, ack}, 32'd0);
        chk("data_frozen", {24'd0, uart_data}, 32'hA5);

        // Spurious done in IDLE, GRANT and START
        uart_done = 1'b1;
        repeat (2) @(negedge clk);
        chk("spur_idle_busy", {31'd0, busy}, 32'd0);
        req = 4'b1000; data[31:24] = 8'h5A; push(3, 8'h5A);
        @(negedge clk);
        chk("spur_grant_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("spur_start", {31'd0, uart_start}, 32'd1);
        uart_done = 1'b0;
        @(negedge clk);
        chk("spur_wait_ack", {28'd0, ack}, 32'd0);
        chk("spur_wait_busy", {31'd0, busy}, 32'd1);
        finish_frame(8'h5A, 2);
        req = '0;
        @(negedge clk);

        // Lock chain on requester 0 with requester 2 pending
        req = 4'b0001; lock = 4'b0001; data[7:0] = 8'h11;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(2, 8'hC2);
        wait_start(lat);
        req[2] = 1'b1; data[23:16] = 8'hC2;
        finish_frame(8'h11, 2);
        data[7:0] = 8'h22;
        wait_start(lat);
        finish_frame(8'h22, 2);
        data[7:0] = 8'h33;
        wait_start(lat);
        finish_frame(8'h33, 2);
        req[0] = 1'b0; lock[0] = 1'b0;

        // Requester 2 served; requester 3 pulses one cycle while busy
        wait_start(lat);
        @(negedge clk);
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        finish_frame(8'hC2, 2);
        req[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        chk("drop_owner", {30'd0, owner}, 32'd2);

        // Reset during WAIT
        req = 4'b0100; data[23:16] = 8'h77; push(2, 8'h77);
        wait_start(lat);
        @(negedge clk);
        reset = 1'b0; req = '0;
        @(negedge clk);
        reset = 1'b1;
        ack_q.delete();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_start", {31'd0, uart_start}, 32'd0);
        chk("mid_rst_ack", {28'd0, ack}, 32'd0);
        chk("mid_rst_data", {24'd0, uart_data}, 32'd0);
        uart_done = 1'b1;
        @(negedge clk);
        uart_done = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", {28'd0, ack}, 32'd0);

        // Fairness with all four requesting
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) push(0, 8'h11);
`else
        for (int i = 0; i < 5; i++) push(i % NUM_REQ, 8'(8'h11 * ((i % NUM_REQ) + 1)));
`endif
        for (int i = 0; i < 5; i++) begin
            logic [7:0] eb;
`ifdef UART_ARB_FIXED_PRIO_EN
            eb = 8'h11;
`else
            eb = 8'(8'h11 * ((i % NUM_REQ) + 1));
`endif
            wait_start(lat);
            finish_frame(eb, 2);
        end
        req = '0;
        repeat (4) @(negedge clk);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
